// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared N:1 data mux.
// Grants one requester at a time for a burst of at most MAX_HOLD beats, with a registered output slot.
module rr_mux_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 8,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDW-1:0]            out_src,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id
);

  localparam int CNTW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]      out_src_q, out_src_d;
  logic                out_last_q, out_last_d;

  logic                found_s;
  logic [IDW-1:0]      pick_s;
  logic                slot_free_s;
  logic                accept_s;
  logic                release_s;
  logic [CNTW-1:0]     beat_inc_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [IDW-1:0]      ptr_next_s;

  // Rotating priority scan: first valid requester starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        pick_s  = IDW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake terms for the granted requester.
  always_comb begin
    slot_free_s = !out_valid_q || out_ready;
    beat_inc_s  = cnt_q + CNTW'(1);
    sel_data_s  = req_data[int'(grant_q)*DATA_W +: DATA_W];
    accept_s    = (state_q == GRANT) && req_valid[grant_q] && slot_free_s;
    release_s   = req_last[grant_q] || (beat_inc_s == CNTW'(MAX_HOLD));
    if (grant_q == IDW'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_q + IDW'(1);
    end
  end

  // req_ready depends only on state and the output slot, never on req_valid.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == GRANT) && (int'(grant_q) == i) && slot_free_s;
    end
  end

  // Next-state computation for the FSM, grant bookkeeping and output slot.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_src_d   = grant_q;
      out_last_d  = release_s;
      cnt_d       = beat_inc_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          grant_d = pick_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A granted requester that stalls keeps the grant indefinitely.
        if (accept_s && release_s) begin
          state_d = IDLE;
          ptr_d   = ptr_next_s;
          grant_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == GRANT);
  assign grant_id  = grant_q;

endmodule
